seq_pattern_tx: RTL

//  Serial pattern transmitter; the source side of the serial sequence-detector link.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_bit_shifter.sv | 54 +++++
 rtl/seq_pattern_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity,
        StDone
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1000;

    function automatic int unsigned cnt_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_bit_shifter.sv
// Rotating pattern register plus bit-index counter; flags the last bit of a repetition.
// Optional parity output when SEQTX_PARITY_EN is defined.
module seq_bit_shifter
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    output logic             bit_out,
    output logic             last_bit
`ifdef SEQTX_PARITY_EN
    ,
    output logic             parity
`endif
);
    localparam int unsigned CNT_W = cnt_width(PAT_W);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    // Rotating rather than shifting restores the pattern after each repetition.
    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load) begin
            sr_d  = pattern;
            idx_d = '0;
        end else if (shift) begin
            sr_d  = {sr_q[PAT_W-2:0], sr_q[PAT_W-1]};
            idx_d = last_bit ? '0 : idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign bit_out  = sr_q[PAT_W-1];
    assign last_bit = (idx_q == CNT_W'(PAT_W - 1));
`ifdef SEQTX_PARITY_EN
    assign parity   = ^sr_q;
`endif

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a pattern MSB-first, reps+1 times back-to-back.
// Define SEQTX_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PAT_W-1:0] s_pattern,
    input  logic [REP_W-1:0] s_reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    state_e           state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic             accept;
    logic             rep_last;
    logic             bit_out;
    logic             last_bit;
`ifdef SEQTX_PARITY_EN
    logic             parity;
`endif

    assign accept   = s_valid && (state_q == StIdle || state_q == StDone);
    assign rep_last = (rep_q == reps_q);

    seq_bit_shifter #(
        .PAT_W(PAT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (state_q == StShift),
        .pattern (s_pattern),
        .bit_out (bit_out),
        .last_bit(last_bit)
`ifdef SEQTX_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rep_q   <= '0;
            reps_q  <= '0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            reps_q  <= reps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        reps_d  = reps_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (s_valid) begin
                    state_d = StShift;
                    rep_d   = '0;
                    reps_d  = s_reps;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (last_bit) begin
`ifdef SEQTX_PARITY_EN
                    state_d = StParity;
`else
                    if (rep_last) begin
                        state_d = StDone;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
            end
`ifdef SEQTX_PARITY_EN
            StParity: begin
                if (rep_last) begin
                    state_d = StDone;
                end else begin
                    state_d = StShift;
                    rep_d   = rep_q + REP_W'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        s_ready    = 1'b0;
        unique case (state_q)
            StIdle: s_ready = 1'b1;
            StShift: begin
                dout       = bit_out;
                dout_valid = 1'b1;
                busy       = 1'b1;
            end
`ifdef SEQTX_PARITY_EN
            StParity: begin
                dout       = parity;
                dout_valid = 1'b1;
                busy       = 1'b1;
            end
`endif
            StDone: begin
                done    = 1'b1;
                s_ready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
